vcsel_seq_ctrl: RTL and testbench
=================================

Name: vcsel_seq_ctrl

Overview:
- Parametrised multi-channel VCSEL firing sequencer; successor to the single-output VCSEL driver path of the core.
- Fires N_CH laser channels round-robin with programmable pulse width, pulse period and burst length.
- Generates two maskable sticky interrupts (burst done, config error) for the INT0/INT1 pads.
- Sits between the SPI register file (config/start/stop) and the VCSEL driver pads.

Parameters:
- N_CH, 4, number of VCSEL channels (1..16)
- CNT_W, 16, width of period counter
- PW_W, 8, width of pulse-width counter
- BST_W, 8, width of burst (round) counter

Ports:
- clk_osc  in  1  system clock
- rst_n  in  1  async active-low reset
- cfg_ch_mask  in  N_CH  channel enable mask
- cfg_period  in  CNT_W  pulse start-to-start period, cycles
- cfg_pulse_w  in  PW_W  pulse high time, cycles (0 treated as 1)
- cfg_burst  in  BST_W  rounds per burst; 0 = continuous
- cfg_int_mask  in  2  bit0 done enable, bit1 error enable
- start  in  1  single-cycle start pulse
- stop  in  1  single-cycle abort pulse
- int_clr  in  2  write-1-to-clear sticky status
- vcsel_drv  out  N_CH  driver outputs, registered, at most one high
- fire_strobe  out  1  high on first cycle of every pulse
- ch_idx  out  $clog2(N_CH) (min 1)  channel currently or last fired
- busy  out  1  sequencer not IDLE
- int_stat  out  2  raw sticky status {err, done}
- int0  out  1  done interrupt = int_stat[0] & cfg_int_mask[0], registered
- int1  out  1  error interrupt = int_stat[1] & cfg_int_mask[1], registered

Behaviour:
- One clock (clk_osc); reset is asynchronous, active-low (rst_n). All outputs reset to 0; FSM to IDLE; all counters 0.
- FSM states: IDLE, PULSE, GAP, DONE.
- IDLE: on start, validate config. Valid requires cfg_ch_mask != 0 and cfg_period > max(cfg_pulse_w, 1).
  - Valid: latch all cfg_* into shadow registers, select lowest enabled channel, go to PULSE. vcsel_drv is high on cycle t+1 after start sampled at t.
  - Invalid: set err status, stay IDLE.
- Config inputs are ignored while busy; shadow registers are used throughout.
- PULSE:
  - vcsel_drv[ch] high for pw cycles (pw = max(cfg_pulse_w, 1)); fire_strobe on the first of these.
  - Period counter runs from the first pulse cycle; after pw cycles go to GAP.
- GAP:
  - All outputs low.
  - When the period counter reaches period-1, advance to the next enabled channel (upward, wrapping) and return to PULSE.
  - Pulse starts are exactly period cycles apart, also across wrap-around.
- Round = one pulse on every enabled channel. The round counter increments when the last enabled channel's GAP ends.
  - If cfg_burst != 0 and round == cfg_burst, go to DONE instead of PULSE.
- DONE: one cycle; set done status; go to IDLE.
- stop (any non-IDLE state): vcsel_drv forced 0 in the next cycle; go to IDLE; no done status. stop in IDLE has no effect.
- start while busy is ignored. Simultaneous start and stop in IDLE: stop has no effect, start is processed.
- Sticky status: set has priority over int_clr in the same cycle. int0/int1 follow int_stat & mask with one cycle of latency.
- cfg_burst = 0: runs until stop; round counter saturates, no wrap.
- Single enabled channel: fires that channel every period.
- vcsel_drv is driven directly from flops (glitch-free) and is never multi-hot.

Decomposition:
- Package vcsel_seq_pkg: state enum (IDLE, PULSE, GAP, DONE), interrupt bit indices INT_DONE=0 and INT_ERR=1, and a next-enabled-channel function (priority search with wrap).
- Sub-module irq_sticky: parametrised width; sticky set/clear, mask, registered output. Instantiated once with width 2.

Test Plan:
- Mask=4'b0101, period=10, pw=3, burst=2, start at t: ch0 high t+1..t+3, ch2 high t+11..t+13, ch0 at t+21, ch2 at t+31; DONE then IDLE; int0=1 at t+42 with mask=2'b01.
- Mask=0 or period=3 with pw=3, start: no vcsel activity, busy stays 0, int_stat=2'b10; int1 asserts only when cfg_int_mask[1]=1; int_clr=2'b10 clears it.
- Burst=0, mask=4'b1000, period=5, pw=0: ch3 pulses 1 cycle every 5 cycles; stop mid-pulse: drv=0 next cycle, busy=0, no done status.
- Config changed while busy (period 10 to 20): spacing stays 10; a second start while busy is ignored.
- int_clr=2'b01 in the same cycle DONE sets done: int_stat[0] remains 1.
- rst_n asserted mid-PULSE: vcsel_drv, busy, int0 and int1 go 0 asynchronously; after release the block is IDLE.

Source files
------------

// File: rtl/vcsel_seq_pkg.sv
// -----------------------------------------------------------------------------
// vcsel_seq_pkg
// Shared types and helpers for the VCSEL firing sequencer.
//   seq_state_e : sequencer FSM states
//   INT_DONE    : int_stat / int_clr / cfg_int_mask bit for burst done
//   INT_ERR     : int_stat / int_clr / cfg_int_mask bit for config error
//   next_ch()   : next enabled channel above 'cur', wrapping, for up to
//                 MAX_CH channels
// -----------------------------------------------------------------------------
package vcsel_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam int INT_DONE = 0;
    localparam int INT_ERR  = 1;
    localparam int INT_W    = 2;

    // Widest supported channel count; the search function works on a
    // mask padded to this width so one function serves every N_CH.
    localparam int MAX_CH   = 16;
    localparam int CH_IDX_W = 4;

    // Search upward from cur+1 through n channels, wrapping at n, and return
    // the first enabled one. If only 'cur' is enabled the search lands on
    // 'cur' itself; if nothing is enabled 'cur' is returned unchanged.
    // Calling it with cur = n-1 yields the lowest enabled channel.
    function automatic logic [CH_IDX_W-1:0] next_ch(
        input logic [MAX_CH-1:0]   mask,
        input logic [CH_IDX_W-1:0] cur,
        input int                  n
    );
        logic [CH_IDX_W-1:0] res;
        logic                found;
        int                  idx;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= MAX_CH; i++) begin
            idx = int'(cur) + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (i <= n) && mask[idx[CH_IDX_W-1:0]]) begin
                res   = idx[CH_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vcsel_seq_ctrl_irq_sticky.sv
// -----------------------------------------------------------------------------
// irq_sticky
// Bank of W sticky status bits with write-1-to-clear and a registered,
// masked interrupt output.
//   clk, rst_n : clock, async active-low reset
//   set        : per-bit set request (wins over clr in the same cycle)
//   clr        : per-bit write-1-to-clear
//   mask       : per-bit interrupt enable
//   stat       : raw sticky status
//   irq        : stat & mask, delayed one cycle
// -----------------------------------------------------------------------------
module irq_sticky #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] set,
    input  logic [W-1:0] clr,
    input  logic [W-1:0] mask,
    output logic [W-1:0] stat,
    output logic [W-1:0] irq
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat <= '0;
            irq  <= '0;
        end else begin
            stat <= (stat & ~clr) | set;
            irq  <= stat & mask;
        end
    end

endmodule

// File: rtl/vcsel_seq_ctrl.sv
// -----------------------------------------------------------------------------
// vcsel_seq_ctrl
// Multi-channel VCSEL firing sequencer. Fires the enabled channels round-robin
// with programmable pulse width, start-to-start period and burst length, and
// raises sticky done/error interrupts.
//   clk_osc, rst_n : clock, async active-low reset
//   cfg_*          : configuration, sampled into shadow registers on start
//   cfg_int_mask   : interrupt enables {err, done}
//   start / stop   : single-cycle start and abort requests
//   int_clr        : write-1-to-clear for int_stat
//   vcsel_drv      : registered one-hot (or zero) driver outputs
//   fire_strobe    : high on the first cycle of every pulse
//   ch_idx         : channel currently or last fired
//   busy           : sequencer not IDLE
//   int_stat       : raw sticky status {err, done}
//   int0 / int1    : registered masked done / error interrupts
// -----------------------------------------------------------------------------
module vcsel_seq_ctrl
    import vcsel_seq_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int CNT_W = 16,
    parameter  int PW_W  = 8,
    parameter  int BST_W = 8,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_osc,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  cfg_ch_mask,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [PW_W-1:0]  cfg_pulse_w,
    input  logic [BST_W-1:0] cfg_burst,
    input  logic [1:0]       cfg_int_mask,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       int_clr,
    output logic [N_CH-1:0]  vcsel_drv,
    output logic             fire_strobe,
    output logic [CH_W-1:0]  ch_idx,
    output logic             busy,
    output logic [1:0]       int_stat,
    output logic             int0,
    output logic             int1
);

    // Common width for comparing period against pulse width.
    localparam int CW = (CNT_W > PW_W) ? CNT_W : PW_W;

    seq_state_e       state_q, state_d;
    logic [N_CH-1:0]  mask_sh;
    logic [CNT_W-1:0] period_sh;
    logic [PW_W-1:0]  pw_sh;
    logic [BST_W-1:0] burst_sh;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [BST_W-1:0] round_q, round_d, round_inc;
    logic [N_CH-1:0]  drv_q, drv_d;
    logic             strobe_q, strobe_d;
    logic             load_cfg;
    logic             done_set, err_set;
    logic [PW_W-1:0]  pw_eff;
    logic             cfg_valid;
    logic [CH_W-1:0]  first_ch, nxt_ch;
    logic             wrap, pulse_end, gap_end;
    logic [INT_W-1:0] irq_set, irq_out;

    // Config qualification on the live inputs (only used in IDLE).
    assign pw_eff    = (cfg_pulse_w == '0) ? PW_W'(1) : cfg_pulse_w;
    assign cfg_valid = (|cfg_ch_mask) && (CW'(cfg_period) > CW'(pw_eff));
    assign first_ch  = CH_W'(next_ch(MAX_CH'(cfg_ch_mask), CH_IDX_W'(N_CH - 1), N_CH));

    // Channel stepping on the shadow mask. A next channel at or below the
    // current one means the last enabled channel just finished: round ends.
    assign nxt_ch    = CH_W'(next_ch(MAX_CH'(mask_sh), CH_IDX_W'(ch_q), N_CH));
    assign wrap      = (nxt_ch <= ch_q);

    // The period counter starts at 0 on the first pulse cycle, so it also
    // times the pulse width; period > pw guarantees at least one GAP cycle.
    assign pulse_end = (CW'(pcnt_q) == (CW'(pw_sh) - CW'(1)));
    assign gap_end   = (pcnt_q == (period_sh - CNT_W'(1)));
    assign round_inc = (round_q == '1) ? round_q : (round_q + BST_W'(1));

    // NOTE: every signal written here gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        ch_d     = ch_q;
        round_d  = round_q;
        drv_d    = '0;
        strobe_d = 1'b0;
        load_cfg = 1'b0;
        done_set = 1'b0;
        err_set  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_valid) begin
                        load_cfg        = 1'b1;
                        ch_d            = first_ch;
                        pcnt_d          = '0;
                        round_d         = '0;
                        drv_d[first_ch] = 1'b1;
                        strobe_d        = 1'b1;
                        state_d         = PULSE;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end

            PULSE: begin
                pcnt_d = pcnt_q + CNT_W'(1);
                if (pulse_end) begin
                    state_d = GAP;
                end else begin
                    drv_d = drv_q;
                end
            end

            GAP: begin
                if (gap_end) begin
                    if (wrap) begin
                        round_d = round_inc;
                    end
                    if (wrap && (burst_sh != '0) && (round_inc == burst_sh)) begin
                        // Done is raised on entry so it is visible during
                        // the DONE cycle itself.
                        state_d  = DONE;
                        done_set = 1'b1;
                    end else begin
                        state_d       = PULSE;
                        ch_d          = nxt_ch;
                        pcnt_d        = '0;
                        drv_d[nxt_ch] = 1'b1;
                        strobe_d      = 1'b1;
                    end
                end else begin
                    pcnt_d = pcnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided.
        if (stop && (state_q != IDLE)) begin
            state_d  = IDLE;
            pcnt_d   = '0;
            ch_d     = ch_q;
            drv_d    = '0;
            strobe_d = 1'b0;
            done_set = 1'b0;
        end
    end

    always_ff @(posedge clk_osc or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pcnt_q   <= '0;
            ch_q     <= '0;
            round_q  <= '0;
            drv_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            ch_q     <= ch_d;
            round_q  <= round_d;
            drv_q    <= drv_d;
            strobe_q <= strobe_d;
        end
    end

    // Shadow configuration, held for the whole burst.
    always_ff @(posedge clk_osc or negedge rst_n) begin
        if (!rst_n) begin
            mask_sh   <= '0;
            period_sh <= '0;
            pw_sh     <= '0;
            burst_sh  <= '0;
        end else if (load_cfg) begin
            mask_sh   <= cfg_ch_mask;
            period_sh <= cfg_period;
            pw_sh     <= pw_eff;
            burst_sh  <= cfg_burst;
        end
    end

    always_comb begin
        irq_set           = '0;
        irq_set[INT_DONE] = done_set;
        irq_set[INT_ERR]  = err_set;
    end

    irq_sticky #(
        .W(INT_W)
    ) u_irq (
        .clk   (clk_osc),
        .rst_n (rst_n),
        .set   (irq_set),
        .clr   (int_clr),
        .mask  (cfg_int_mask),
        .stat  (int_stat),
        .irq   (irq_out)
    );

    assign vcsel_drv   = drv_q;
    assign fire_strobe = strobe_q;
    assign ch_idx      = ch_q;
    assign busy        = (state_q != IDLE);
    assign int0        = irq_out[INT_DONE];
    assign int1        = irq_out[INT_ERR];

endmodule

// File: tb/tb_vcsel_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vcsel_seq_ctrl
// Directed bench for vcsel_seq_ctrl (N_CH=4). Inputs change and outputs are
// sampled 1 ns after each rising edge; cycle k=1 is the first cycle after the
// edge that samples start.
// -----------------------------------------------------------------------------
module tb_vcsel_seq_ctrl;

    logic        clk_osc = 1'b0;
    logic        rst_n;
    logic [3:0]  cfg_ch_mask;
    logic [15:0] cfg_period;
    logic [7:0]  cfg_pulse_w;
    logic [7:0]  cfg_burst;
    logic [1:0]  cfg_int_mask;
    logic        start;
    logic        stop;
    logic [1:0]  int_clr;
    logic [3:0]  vcsel_drv;
    logic        fire_strobe;
    logic [1:0]  ch_idx;
    logic        busy;
    logic [1:0]  int_stat;
    logic        int0;
    logic        int1;

    int checks = 0;
    int errors = 0;

    vcsel_seq_ctrl dut (
        .clk_osc      (clk_osc),
        .rst_n        (rst_n),
        .cfg_ch_mask  (cfg_ch_mask),
        .cfg_period   (cfg_period),
        .cfg_pulse_w  (cfg_pulse_w),
        .cfg_burst    (cfg_burst),
        .cfg_int_mask (cfg_int_mask),
        .start        (start),
        .stop         (stop),
        .int_clr      (int_clr),
        .vcsel_drv    (vcsel_drv),
        .fire_strobe  (fire_strobe),
        .ch_idx       (ch_idx),
        .busy         (busy),
        .int_stat     (int_stat),
        .int0         (int0),
        .int1         (int1)
    );

    always #5 clk_osc = ~clk_osc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_osc);
        #1;
    endtask

    task automatic set_cfg(input logic [3:0] m, input logic [15:0] p,
                           input logic [7:0] w, input logic [7:0] b);
        cfg_ch_mask = m;
        cfg_period  = p;
        cfg_pulse_w = w;
        cfg_burst   = b;
    endtask

    initial begin
        logic [3:0] e_drv;
        int         m;

        rst_n        = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        int_clr      = 2'b00;
        cfg_int_mask = 2'b00;
        set_cfg(4'b0000, 16'd0, 8'd0, 8'd0);

        // ---- reset state ----
        repeat (2) @(posedge clk_osc);
        #1;
        check("rst drv", 32'(vcsel_drv), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst stat", 32'(int_stat), 32'h0);
        check("rst strobe", 32'(fire_strobe), 32'h0);
        check("rst ch_idx", 32'(ch_idx), 32'h0);
        check("rst irq", 32'({int1, int0}), 32'h0);
        rst_n = 1'b1;
        tick();

        // ---- 1: mask 0101, period 10, pw 3, burst 2 ----
        set_cfg(4'b0101, 16'd10, 8'd3, 8'd2);
        cfg_int_mask = 2'b01;
        start = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            tick();
            start = 1'b0;
            e_drv = 4'b0000;
            if ((k >= 1 && k <= 3) || (k >= 21 && k <= 23)) e_drv = 4'b0001;
            if ((k >= 11 && k <= 13) || (k >= 31 && k <= 33)) e_drv = 4'b0100;
            check($sformatf("t1 drv k=%0d", k), 32'(vcsel_drv), 32'(e_drv));
            check($sformatf("t1 strobe k=%0d", k), 32'(fire_strobe),
                  32'((k == 1) || (k == 11) || (k == 21) || (k == 31)));
            check($sformatf("t1 busy k=%0d", k), 32'(busy), 32'(k <= 41));
            if (k == 1)  check("t1 ch_idx k=1", 32'(ch_idx), 32'd0);
            if (k == 11) check("t1 ch_idx k=11", 32'(ch_idx), 32'd2);
            if (k == 40) check("t1 stat k=40", 32'(int_stat), 32'h0);
            if (k == 41) begin
                check("t1 stat k=41", 32'(int_stat), 32'h1);
                check("t1 int0 k=41", 32'(int0), 32'h0);
            end
            if (k == 42) check("t1 int0 k=42", 32'(int0), 32'h1);
            if (k == 44) check("t1 ch_idx last", 32'(ch_idx), 32'd2);
        end
        int_clr = 2'b01;
        tick();
        int_clr = 2'b00;
        check("t1 clr stat", 32'(int_stat), 32'h0);
        tick();
        check("t1 clr int0", 32'(int0), 32'h0);

        // ---- 2: invalid configs -> error status ----
        cfg_int_mask = 2'b00;
        set_cfg(4'b0000, 16'd10, 8'd3, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2 busy mask0", 32'(busy), 32'h0);
        check("t2 drv mask0", 32'(vcsel_drv), 32'h0);
        check("t2 stat mask0", 32'(int_stat), 32'h2);
        tick();
        check("t2 int1 masked", 32'(int1), 32'h0);
        cfg_int_mask = 2'b10;
        tick();
        check("t2 int1 enabled", 32'(int1), 32'h1);
        int_clr = 2'b10;
        tick();
        int_clr = 2'b00;
        check("t2 clr stat", 32'(int_stat), 32'h0);
        tick();
        check("t2 clr int1", 32'(int1), 32'h0);
        set_cfg(4'b0101, 16'd3, 8'd3, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2 busy p3w3", 32'(busy), 32'h0);
        check("t2 stat p3w3", 32'(int_stat), 32'h2);
        tick();
        check("t2 drv p3w3", 32'(vcsel_drv), 32'h0);
        int_clr = 2'b10;
        tick();
        int_clr = 2'b00;
        cfg_int_mask = 2'b00;
        tick();

        // ---- 3: continuous, single channel 3, pw 0, then stop mid-pulse ----
        set_cfg(4'b1000, 16'd5, 8'd0, 8'd0);
        start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            start = 1'b0;
            check($sformatf("t3 drv k=%0d", k), 32'(vcsel_drv),
                  ((k % 5) == 1) ? 32'h8 : 32'h0);
            if (k == 1) check("t3 ch_idx", 32'(ch_idx), 32'd3);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t3 stop drv", 32'(vcsel_drv), 32'h0);
        check("t3 stop busy", 32'(busy), 32'h0);
        check("t3 stop stat", 32'(int_stat), 32'h0);
        tick();
        check("t3 stop stat+1", 32'(int_stat), 32'h0);
        check("t3 stop drv+1", 32'(vcsel_drv), 32'h0);

        // ---- 4: config change and restart while busy are ignored ----
        set_cfg(4'b0011, 16'd10, 8'd2, 8'd0);
        start = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            tick();
            start = 1'b0;
            m = (k - 1) / 10;
            e_drv = (((k - 1) % 10) < 2) ? (4'b0001 << (m % 2)) : 4'b0000;
            check($sformatf("t4 drv k=%0d", k), 32'(vcsel_drv), 32'(e_drv));
            if (k == 1) set_cfg(4'b1111, 16'd20, 8'd5, 8'd1);
            if (k == 5) start = 1'b1;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t4 stop busy", 32'(busy), 32'h0);
        check("t4 stat", 32'(int_stat), 32'h0);

        // ---- 5: int_clr coincident with done set; set wins ----
        set_cfg(4'b0001, 16'd4, 8'd1, 8'd1);
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            start   = 1'b0;
            int_clr = 2'b00;
            if (k == 1) check("t5 drv k=1", 32'(vcsel_drv), 32'h1);
            if (k == 2) check("t5 drv k=2", 32'(vcsel_drv), 32'h0);
            if (k == 4) begin
                check("t5 stat pre", 32'(int_stat), 32'h0);
                int_clr = 2'b01;
            end
            if (k == 5) begin
                check("t5 stat set wins", 32'(int_stat), 32'h1);
                check("t5 busy done", 32'(busy), 32'h1);
            end
            if (k == 6) begin
                check("t5 busy idle", 32'(busy), 32'h0);
                check("t5 stat held", 32'(int_stat), 32'h1);
            end
        end

        // ---- 6: async reset mid-pulse ----
        cfg_int_mask = 2'b11;
        set_cfg(4'b0000, 16'd10, 8'd5, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t6 pre int0", 32'(int0), 32'h1);
        check("t6 pre int1", 32'(int1), 32'h1);
        set_cfg(4'b0001, 16'd10, 8'd5, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t6 pulse drv", 32'(vcsel_drv), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 rst drv", 32'(vcsel_drv), 32'h0);
        check("t6 rst busy", 32'(busy), 32'h0);
        check("t6 rst irq", 32'({int1, int0}), 32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        check("t6 post busy", 32'(busy), 32'h0);
        check("t6 post drv", 32'(vcsel_drv), 32'h0);
        check("t6 post stat", 32'(int_stat), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6 restart drv", 32'(vcsel_drv), 32'h1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t6 final busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
